// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared types and constants for the projection scheduler:
//                coordinates, screen geometry, reset defaults, pipeline
//                request/response structs and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    typedef logic [9:0] coord_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int HALF_W   = 160;
    localparam int HALF_H   = 120;
    localparam int Z_OFFSET = 128;
    localparam int SIZE_MAX = 63;

    // Fixed latency of proj_unit (request sample edge to back-bank write)
    localparam int PROJ_LAT = 2;

    // Object index carried through the pipeline (covers up to 16 objects)
    localparam int IDX_W = 4;

    // Values every bank entry holds after reset
    localparam coord_t RST_CX = 10'd320;
    localparam coord_t RST_CY = 10'd240;
    localparam coord_t RST_SZ = 10'd8;

    typedef struct packed {
        coord_t             x;
        coord_t             y;
        coord_t             z;
        logic [IDX_W-1:0]   idx;
        logic               valid;
    } proj_req_t;

    typedef struct packed {
        coord_t             cx;
        coord_t             cy;
        coord_t             sz;
        logic [IDX_W-1:0]   idx;
        logic               valid;
    } proj_rsp_t;

    // Scheduler state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_SWAP  = 2'd3;

    // Saturate a 12-bit signed value into 0..hi
    function automatic coord_t sat12(input logic signed [11:0] v,
                                     input logic signed [11:0] hi);
        coord_t r;
        if (v < 12'sd0) begin
            r = '0;
        end else if (v > hi) begin
            r = hi[9:0];
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/proj_unit.sv
`default_nettype none
// ============================================================================
//  Module      : proj_unit
//  Description : Two-stage pipelined perspective projection. Stage 1 forms
//                the products, stage 2 shifts/adds (and saturates when
//                PROJ_CLAMP_EN is defined). The object index rides along.
//                Macro: PROJ_CLAMP_EN (defined -> saturate, else wrap 1024).
//  Revision    : 1.0 - initial release
// ============================================================================
module proj_unit
    import pong_pkg::*;
(
    input  logic      Clk,
    input  logic      Reset,
    input  proj_req_t req_i,
    output proj_rsp_t rsp_o
);

    // Stage-1 combinational products
    logic [10:0] w_zp;
    logic [20:0] w_px;
    logic [20:0] w_py;
    logic [17:0] w_zx;
    logic [17:0] w_zy;

    assign w_zp = {1'b0, req_i.z} + 11'(Z_OFFSET);
    assign w_px = {10'd0, w_zp} * {11'd0, req_i.x};
    assign w_py = {10'd0, w_zp} * {11'd0, req_i.y};
    assign w_zx = 18'(HALF_W) * {8'd0, req_i.z};
    assign w_zy = 18'(HALF_H) * {8'd0, req_i.z};

    logic [20:0]      s1_px_q;
    logic [20:0]      s1_py_q;
    logic [17:0]      s1_zx_q;
    logic [17:0]      s1_zy_q;
    logic [10:0]      s1_zp_q;
    logic [IDX_W-1:0] s1_idx_q;
    logic             s1_vld_q;

    // Stage 1: register products, index and valid
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_px_q  <= '0;
            s1_py_q  <= '0;
            s1_zx_q  <= '0;
            s1_zy_q  <= '0;
            s1_zp_q  <= '0;
            s1_idx_q <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_px_q  <= w_px;
            s1_py_q  <= w_py;
            s1_zx_q  <= w_zx;
            s1_zy_q  <= w_zy;
            s1_zp_q  <= w_zp;
            s1_idx_q <= req_i.idx;
            s1_vld_q <= req_i.valid;
        end
    end

    // Sums formed modulo 2^12 and interpreted as signed
    logic signed [11:0] w_cx;
    logic signed [11:0] w_cy;
    logic signed [11:0] w_sz;

    assign w_cx = 12'(21'(HALF_W) + (s1_px_q >> 8) - 21'(s1_zx_q >> 7));
    assign w_cy = 12'(21'(HALF_H) + (s1_py_q >> 8) - 21'(s1_zy_q >> 7));
    assign w_sz = 12'(s1_zp_q >> 3);

    coord_t w_cx_fin;
    coord_t w_cy_fin;
    coord_t w_sz_fin;

`ifdef PROJ_CLAMP_EN
    assign w_cx_fin = sat12(w_cx, 12'(SCREEN_W - 1));
    assign w_cy_fin = sat12(w_cy, 12'(SCREEN_H - 1));
    assign w_sz_fin = sat12(w_sz, 12'(SIZE_MAX));
`else
    assign w_cx_fin = 10'(w_cx);
    assign w_cy_fin = 10'(w_cy);
    assign w_sz_fin = 10'(w_sz);
`endif

    // Stage 2: register final screen-space result
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rsp_o <= '0;
        end else begin
            rsp_o.cx    <= w_cx_fin;
            rsp_o.cy    <= w_cy_fin;
            rsp_o.sz    <= w_sz_fin;
            rsp_o.idx   <= s1_idx_q;
            rsp_o.valid <= s1_vld_q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/proj_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : proj_scheduler
//  Description : Per-frame scheduler sharing one proj_unit among N_OBJ
//                objects. Issues one projection per cycle, collects results
//                in a back bank and swaps it to the front bank at once.
//                Macro: PROJ_CLAMP_EN (saturating results inside proj_unit).
//  Revision    : 1.0 - initial release
// ============================================================================
module proj_scheduler
    import pong_pkg::*;
#(
    parameter int N_OBJ = 4
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        frame_start,
    output logic [$clog2(N_OBJ)-1:0]    obj_sel,
    input  logic [9:0]                  pos_x,
    input  logic [9:0]                  pos_y,
    input  logic [9:0]                  pos_z,
    output logic [N_OBJ-1:0][9:0]       center_x,
    output logic [N_OBJ-1:0][9:0]       center_y,
    output logic [N_OBJ-1:0][9:0]       size,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overrun
);

    localparam int                CNT_W    = $clog2(N_OBJ);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_OBJ - 1);
    localparam logic              DRN_LAST = 1'(PROJ_LAT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drain_q, drain_d;
    logic               done_q;
    logic               ovr_q;

    logic [N_OBJ-1:0][9:0] back_cx_q, back_cy_q, back_sz_q;
    logic [N_OBJ-1:0][9:0] front_cx_q, front_cy_q, front_sz_q;

    proj_req_t w_req;
    proj_rsp_t w_rsp;

    // Next-state logic for the FSM, issue counter and drain counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    // counter holds the last issued index outside RUN
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRN_LAST) begin
                    state_d = ST_SWAP;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, counters, done pulse and sticky overrun registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            done_q  <= (state_q == ST_SWAP);
            if (frame_start && (state_q != ST_IDLE)) begin
                ovr_q <= 1'b1;
            end
        end
    end

    // Issue the currently selected object while in RUN
    always_comb begin
        w_req       = '0;
        w_req.x     = pos_x;
        w_req.y     = pos_y;
        w_req.z     = pos_z;
        w_req.idx   = IDX_W'(cnt_q);
        w_req.valid = (state_q == ST_RUN);
    end

    proj_unit u_proj_unit (
        .Clk   (Clk),
        .Reset (Reset),
        .req_i (w_req),
        .rsp_o (w_rsp)
    );

    // Back bank collects results by index; front bank takes it whole on SWAP
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N_OBJ; i++) begin
                back_cx_q[i]  <= RST_CX;
                back_cy_q[i]  <= RST_CY;
                back_sz_q[i]  <= RST_SZ;
                front_cx_q[i] <= RST_CX;
                front_cy_q[i] <= RST_CY;
                front_sz_q[i] <= RST_SZ;
            end
        end else begin
            for (int i = 0; i < N_OBJ; i++) begin
                if (w_rsp.valid && (w_rsp.idx == IDX_W'(i))) begin
                    back_cx_q[i] <= w_rsp.cx;
                    back_cy_q[i] <= w_rsp.cy;
                    back_sz_q[i] <= w_rsp.sz;
                end
            end
            if (state_q == ST_SWAP) begin
                front_cx_q <= back_cx_q;
                front_cy_q <= back_cy_q;
                front_sz_q <= back_sz_q;
            end
        end
    end

    assign obj_sel    = cnt_q;
    assign center_x   = front_cx_q;
    assign center_y   = front_cy_q;
    assign size       = front_sz_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;
    assign overrun    = ovr_q;

endmodule
`default_nettype wire

// File: doc/proj_scheduler.md
# proj_scheduler

Per-frame scheduler that shares one pipelined perspective-projection unit among N_OBJ scene objects (ball, paddles, room markers). On each frame start it reads every object's 3D position through an index port and issues one projection per cycle. It writes the screen-space center and size into a back bank and swaps that bank to the outputs once all results are in. It sits between the game-logic position registers and the sprite/colour mapper, so the mapper always sees a coherent set of projections for the whole frame.

## Interface
Parameters:
- N_OBJ, 4, number of objects projected per frame (2..16)

Ports:
- Clk  input  1  system clock (50 MHz)
- Reset  input  1  asynchronous, active-high
- frame_start  input  1  one-cycle pulse, synchronous to Clk (synchronized vsync)
- obj_sel  output  $clog2(N_OBJ)  index of object whose position is being read
- pos_x, pos_y, pos_z  input  10 each  position of object obj_sel; combinational lookup, sampled same cycle
- center_x  output  [N_OBJ][10]  projected screen x per object (front bank)
- center_y  output  [N_OBJ][10]  projected screen y per object (front bank)
- size  output  [N_OBJ][10]  projected sprite half-size per object (front bank)
- busy  output  1  high in any state other than IDLE
- frame_done  output  1  one-cycle pulse, asserted in the cycle after the bank swap
- overrun  output  1  sticky; set when frame_start arrives while not IDLE

## Operation
- States:
  - IDLE: frame_start = 1 → RUN, issue counter cleared.
  - RUN: issue index = counter; obj_sel = counter; counter increments each cycle. After issuing N_OBJ−1 → DRAIN.
  - DRAIN: waits PROJ_LAT cycles for in-flight results → SWAP.
  - SWAP: front bank ← back bank → IDLE.
- Projection, computed by proj_unit:
  - center_x = 160 + (((z+128)·x) >> 8) − ((160·z) >> 7)
  - center_y = 120 + (((z+128)·y) >> 8) − ((120·z) >> 7)
  - size = (z+128) >> 3
- Widths: z+128 is 11-bit unsigned; products are 21-bit unsigned; the sum is formed at 12 bits signed.
- Result without clamp: the low 10 bits are kept, so results wrap modulo 1024.
- Each result carries its object index through the pipeline. It is written to back-bank entry [index] when it emerges.
- frame_start outside IDLE (RUN, DRAIN, SWAP): ignored and overrun ← 1. The sequence in progress is unaffected.
- frame_start in the same cycle as the SWAP→IDLE transition: counts as overrun. Only IDLE accepts a start.
- obj_sel holds its last issued value outside RUN.
- Reset, asynchronous at any time:
  - State → IDLE, counter → 0, obj_sel → 0.
  - All entries in both banks: center_x = 320, center_y = 240, size = 8.
  - busy, frame_done and overrun → 0.
  - proj_unit pipeline valid bits → 0.

## Timing
- PROJ_LAT = 2 (fixed): proj_unit inputs are sampled at edge k; the result is written to the back bank at edge k+2.
- Cycle numbering: frame_start is sampled at edge 0. Object i is sampled at edge i+1.
- Result i is written at edge i+3. The last result is written at edge N_OBJ+2.
- Swap happens at edge N_OBJ+3; frame_done is high for exactly one cycle after edge N_OBJ+3.
- busy is high from after edge 0 until edge N_OBJ+3.
- Total latency: N_OBJ+3 cycles (7 for N_OBJ = 4).
- Front-bank outputs change only at the swap edge, or on Reset.

## Configuration
- PROJ_CLAMP_EN:
  - Defined: the 12-bit signed results saturate. center_x clamps to 0..639, center_y to 0..479, size to 0..63. Adds one compare stage inside proj_unit's final stage; latency unchanged.
  - Undefined: results wrap modulo 1024 as described above.

## Structure
- Shared package pong_pkg:
  - typedef coord_t (logic [9:0])
  - screen constants SCREEN_W = 640, SCREEN_H = 480, HALF_W = 160, HALF_H = 120, Z_OFFSET = 128
  - reset-default constants (320, 240, 8)
  - proj_req_t struct {x, y, z, idx, valid}
  - proj_rsp_t struct {cx, cy, sz, idx, valid}
  - state enum
- Sub-module proj_unit: 2-stage pipeline. Stage 1 forms the multiplies; stage 2 does shift/add plus optional clamp.
- proj_scheduler contains the FSM, issue counter, back/front banks and overrun logic.

## Test plan
1. Reset mid-RUN → all outputs 320/240/8; busy, frame_done and overrun = 0; next frame_start produces normal results.
2. Object 0 at (160,120,0) → after frame_done: center_x 240, center_y 180, size 16.
3. Object 1 at (320,240,128) → center_x 320, center_y 240, size 32. frame_done pulse is 7 cycles after frame_start (N_OBJ = 4).
4. Object at (0,0,255):
   - Without PROJ_CLAMP_EN → center_x 866 (−158 wrapped).
   - With PROJ_CLAMP_EN → center_x 0.
5. Second frame_start 3 cycles after the first → ignored; overrun = 1 and stays set; first frame's results correct; overrun persists until Reset.
6. Change pos inputs between frames → front bank unchanged until the swap edge, then all N_OBJ entries update in the same cycle.
